// File: rtl/fifo_drain_pkg.sv
// Shared definitions for the buffer read-side controller: state encoding,
// default word width and the even-parity helper also used on the writer side.
package fifo_drain_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int PAR_MAX_W  = 64;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_READ  = S_READ,
    ST_LATCH = S_LATCH,
    ST_HOLD  = S_HOLD
  } state_t;

  // Zero-extending a word does not change its parity, so one wide version serves every width.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/fifo_drain_hold_timer.sv
// Counts tick pulses while a word is on display; done once the loaded limit
// is reached, or immediately while bypass (flush) is high.
module hold_timer
  import fifo_drain_pkg::*;
#(
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [HOLD_W-1:0] i_lim,
  input  logic              i_clear,
  input  logic              i_count_en,
  input  logic              i_tick,
  input  logic              i_bypass,
  output logic              o_done
);

  logic [HOLD_W-1:0] r_cnt;
  logic [HOLD_W-1:0] r_lim;

  // Loading restarts the count, so a tick landing in the load cycle is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_lim <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
      r_lim <= i_lim;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count_en && i_tick && (r_cnt < r_lim)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_done = i_bypass || (r_cnt == r_lim);

endmodule

// File: rtl/fifo_drain.sv
// Read-side controller for the clock-crossing word buffer: pops words, checks
// their parity and holds each one on the display path for a number of ticks.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int HOLD_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [HOLD_W-1:0] hold_ticks,
  input  logic              drain,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_par,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              par_err,
  output logic [ERR_W-1:0]  err_count,
  output logic              busy,
  output logic              drained
);

  state_t            r_state;
  logic              r_rd_en;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_par_err;
  logic [ERR_W-1:0]  r_err_count;
  logic              r_busy;
  logic              r_drained;

  logic w_hold_done;
  logic w_par_mismatch;

  assign w_par_mismatch = even_parity(PAR_MAX_W'(fifo_data)) != fifo_par;

  hold_timer #(
    .HOLD_W (HOLD_W)
  ) u_hold_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (r_state == ST_LATCH),
    .i_lim      (hold_ticks),
    .i_clear    (r_state == ST_IDLE),
    .i_count_en (r_state == ST_HOLD),
    .i_tick     (tick),
    .i_bypass   (drain),
    .o_done     (w_hold_done)
  );

  // The pop strobe and busy are set on the transition into a state, so they
  // line up with READ and with every non-IDLE cycle without combinational decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rd_en     <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_par_err   <= 1'b0;
      r_err_count <= '0;
      r_busy      <= 1'b0;
      r_drained   <= 1'b0;
    end else begin
      r_rd_en   <= 1'b0;
      r_valid   <= 1'b0;
      r_drained <= drain && (r_state == ST_IDLE) && fifo_empty;
      case (r_state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            r_state <= ST_READ;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_READ: begin
          r_state <= ST_LATCH;
        end
        ST_LATCH: begin
          r_data  <= fifo_data;
          r_valid <= 1'b1;
          if (w_par_mismatch) begin
            r_par_err <= 1'b1;
            if (r_err_count != {ERR_W{1'b1}}) begin
              r_err_count <= r_err_count + 1'b1;
            end
          end
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (w_hold_done) begin
            if (!fifo_empty) begin
              r_state <= ST_READ;
              r_rd_en <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en = r_rd_en;
  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign par_err    = r_par_err;
  assign err_count  = r_err_count;
  assign busy       = r_busy;
  assign drained    = r_drained;

endmodule
